// File: rtl/smult_seq.sv
// Scalar x 16-lane half-precision multiply on a 4-lane VMULT bank, 4 lanes per beat.
// Latency: 4 cycles from accepted start to done; start is ignored (not queued) while busy.

module VMULT (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] product,
    output logic        Overflow
);
    logic        sgn;
    logic [10:0] sig_a, sig_b;
    logic [5:0]  exp_a, exp_b;
    logic [21:0] prod;
    logic [4:0]  lead;
    logic [47:0] wide;
    logic [12:0] t;
    logic [11:0] mant;
    logic        sticky;
    int          e, s, base, r;

    // Exponent field 31 is treated as an ordinary finite exponent; anything that
    // rounds to 0x7c00 or above saturates to signed 0x7c00 and raises Overflow.
    always_comb begin
        sgn   = A[15] ^ B[15];
        sig_a = {|A[14:10], A[9:0]};
        sig_b = {|B[14:10], B[9:0]};
        exp_a = (A[14:10] == 5'd0) ? 6'd1 : {1'b0, A[14:10]};
        exp_b = (B[14:10] == 5'd0) ? 6'd1 : {1'b0, B[14:10]};
        prod  = sig_a * sig_b;
        lead  = 5'd0;
        for (int i = 0; i < 22; i++) begin
            if (prod[i]) lead = 5'(i);
        end
        e = int'(lead) + int'(exp_a) + int'(exp_b) - 35;
        // right shift that lands the leading one on bit 10, plus denormalisation
        s = int'(lead) - 10 + ((e < 1) ? (1 - e) : 0) + 16;
        if (s > 47) s = 47;
        wide   = {10'b0, prod, 16'b0};
        t      = 13'(wide >> (s - 1));
        sticky = |(wide & ((48'd1 << (s - 1)) - 48'd1));
        mant   = t[12:1] + {11'b0, t[0] & (sticky | t[1])};
        base   = (e >= 1) ? (e - 1) : 0;
        r      = base * 1024 + int'(mant);
        product  = {sgn, r[14:0]};
        Overflow = 1'b0;
        if (prod == 22'd0) begin
            product = {sgn, 15'h0000};
        end else if (r >= 31 * 1024) begin
            product  = {sgn, 15'h7c00};
            Overflow = 1'b1;
        end
    end
endmodule

module smult_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  scalar,
    input  logic [255:0] vecin,
    output logic         busy,
    output logic         done,
    output logic [255:0] product,
    output logic         Ovrflw
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state;
    logic [15:0]    scalar_q;
    logic [255:0]   vec_q;
    logic [191:0]   stage_q;
    logic           ov_q;
    logic [1:0]     beat;
    logic [63:0]    beat_prod;
    logic [3:0]     beat_ov;

    for (genvar k = 0; k < 4; k++) begin : g_mul
        VMULT u_vmult (
            .product  (beat_prod[16*k +: 16]),
            .Overflow (beat_ov[k]),
            .A        (scalar_q),
            .B        (vec_q[{beat, 2'(k), 4'b0000} +: 16])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            Ovrflw   <= 1'b0;
            beat     <= 2'd0;
            ov_q     <= 1'b0;
            stage_q  <= '0;
            scalar_q <= '0;
            vec_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        scalar_q <= scalar;
                        vec_q    <= vecin;
                        beat     <= 2'd0;
                        ov_q     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    ov_q <= ov_q | (|beat_ov);
                    beat <= beat + 2'd1;
                    case (beat)
                        2'd0: stage_q[63:0]    <= beat_prod;
                        2'd1: stage_q[127:64]  <= beat_prod;
                        2'd2: stage_q[191:128] <= beat_prod;
                        default: begin
                            // last beat goes straight to the output, never through stage_q
                            product <= {beat_prod, stage_q};
                            Ovrflw  <= ov_q | (|beat_ov);
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smult_seq.sv
// Bench for smult_seq: scoreboard of expected products, one task per scenario.
module tb_smult_seq;
    logic         clk, rst, start;
    logic [15:0]  scalar;
    logic [255:0] vecin;
    logic         busy, done, Ovrflw;
    logic [255:0] product;

    int total = 0;
    int bad   = 0;
    logic [255:0] q_prod[$];
    logic         q_ov[$];

    smult_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .scalar  (scalar),
        .vecin   (vecin),
        .busy    (busy),
        .done    (done),
        .product (product),
        .Ovrflw  (Ovrflw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op(input logic [15:0] s, input logic [255:0] v,
                         output int lat, output int nbusy, output bit got);
        scalar = s;
        vecin  = v;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; nbusy = 0; got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; scalar = 16'h3c00; vecin = {16{16'h3c00}};
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (product !== 256'd0) begin bad++; $display("FAIL reset_product: got %h want 0", product); end
        total++; if (Ovrflw !== 1'b0) begin bad++; $display("FAIL reset_ovrflw: got %b want 0", Ovrflw); end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, nbusy; bit got; logic [255:0] ep; logic eo;
        q_prod.push_back({16{16'h3c00}}); q_ov.push_back(1'b0);
        do_op(16'h3c00, {16{16'h3c00}}, lat, nbusy, got);
        ep = q_prod.pop_front(); eo = q_ov.pop_front();
        total++; if (!got) begin bad++; $display("FAIL basic_timeout: no done seen, want done within 12 cycles"); end
        total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
        total++; if (nbusy !== 4) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 4", nbusy); end
        total++; if (product !== ep) begin bad++; $display("FAIL basic_product: got %h want %h", product, ep); end
        total++; if (Ovrflw !== eo) begin bad++; $display("FAIL basic_ovrflw: got %b want %b", Ovrflw, eo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_sign_b2b;
        int cyc, ndone, overlap, twice, nacc, a;
        bit prev_done; logic [255:0] ep; logic eo;
        int acc_q[$];
        for (int k = 0; k < 3; k++) begin
            q_prod.push_back({16{16'hbc00}}); q_ov.push_back(1'b0);
        end
        scalar = 16'hbc00; vecin = {16{16'h3c00}}; start = 1'b1;
        cyc = 0; ndone = 0; overlap = 0; twice = 0; nacc = 0; prev_done = 1'b0;
        while (cyc < 60 && ndone < 3) begin
            if (nacc == 3) start = 1'b0;
            if (start && !busy) begin
                acc_q.push_back(cyc + 1);
                nacc++;
            end
            @(negedge clk);
            cyc++;
            if (busy && done) overlap++;
            if (done && prev_done) twice++;
            prev_done = done;
            if (done) begin
                ndone++;
                ep = q_prod.pop_front(); eo = q_ov.pop_front(); a = acc_q.pop_front();
                total++; if (product !== ep) begin bad++; $display("FAIL b2b_product: got %h want %h", product, ep); end
                total++; if (Ovrflw !== eo) begin bad++; $display("FAIL b2b_ovrflw: got %b want %b", Ovrflw, eo); end
                total++; if (cyc - a !== 4) begin bad++; $display("FAIL b2b_latency: got %0d want 4", cyc - a); end
            end
        end
        start = 1'b0;
        total++; if (ndone !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", ndone); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_busy_done_overlap: got %0d want 0", overlap); end
        total++; if (twice !== 0) begin bad++; $display("FAIL b2b_done_consecutive: got %0d want 0", twice); end
    endtask

    task automatic test_overflow_all;
        int lat, nbusy; bit got; logic [255:0] ep; logic eo;
        q_prod.push_back({16{16'h7c00}}); q_ov.push_back(1'b1);
        do_op(16'h7ccc, {16{16'h7cde}}, lat, nbusy, got);
        ep = q_prod.pop_front(); eo = q_ov.pop_front();
        total++; if (!got) begin bad++; $display("FAIL ovf_all_timeout: no done seen, want done within 12 cycles"); end
        total++; if (product !== ep) begin bad++; $display("FAIL ovf_all_product: got %h want %h", product, ep); end
        total++; if (Ovrflw !== eo) begin bad++; $display("FAIL ovf_all_ovrflw: got %b want %b", Ovrflw, eo); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        scalar = 16'h3c00; vecin = {16{16'h4000}}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (product !== 256'd0) begin bad++; $display("FAIL rstmid_product: got %h want 0", product); end
        total++; if (Ovrflw !== 1'b0) begin bad++; $display("FAIL rstmid_ovrflw: got %b want 0", Ovrflw); end
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", ndone); end
    endtask

    task automatic test_single_lane;
        int lat, nbusy; bit got; logic [255:0] v, x, ep; logic eo;
        for (int i = 0; i < 16; i++) begin
            v[16*i +: 16] = (i == 13) ? 16'h7bff : 16'h0201;
            x[16*i +: 16] = (i == 13) ? 16'h7c00 : 16'h0241;
        end
        q_prod.push_back(x); q_ov.push_back(1'b1);
        do_op(16'h3c80, v, lat, nbusy, got);
        ep = q_prod.pop_front(); eo = q_ov.pop_front();
        total++; if (!got) begin bad++; $display("FAIL lane13_timeout: no done seen, want done within 12 cycles"); end
        total++; if (product !== ep) begin bad++; $display("FAIL lane13_product: got %h want %h", product, ep); end
        total++; if (Ovrflw !== eo) begin bad++; $display("FAIL lane13_ovrflw: got %b want %b", Ovrflw, eo); end
        q_prod.push_back({16{16'h0241}}); q_ov.push_back(1'b0);
        do_op(16'h3c80, {16{16'h0201}}, lat, nbusy, got);
        ep = q_prod.pop_front(); eo = q_ov.pop_front();
        total++; if (!got) begin bad++; $display("FAIL sticky_timeout: no done seen, want done within 12 cycles"); end
        total++; if (product !== ep) begin bad++; $display("FAIL sticky_product: got %h want %h", product, ep); end
        total++; if (Ovrflw !== eo) begin bad++; $display("FAIL sticky_ovrflw_cleared: got %b want %b", Ovrflw, eo); end
    endtask

    // scaling by 2.0 bumps each lane's exponent by one; distinct lanes expose ordering errors
    task automatic test_lanes;
        int lat, nbusy; bit got; logic [255:0] v, x, ep; logic eo;
        for (int i = 0; i < 16; i++) begin
            v[16*i +: 16] = {i[0], 5'(8 + i), 10'h155};
            x[16*i +: 16] = {i[0], 5'(9 + i), 10'h155};
        end
        q_prod.push_back(x); q_ov.push_back(1'b0);
        do_op(16'h4000, v, lat, nbusy, got);
        ep = q_prod.pop_front(); eo = q_ov.pop_front();
        total++; if (!got) begin bad++; $display("FAIL lanes_timeout: no done seen, want done within 12 cycles"); end
        total++; if (product !== ep) begin bad++; $display("FAIL lanes_product: got %h want %h", product, ep); end
        total++; if (Ovrflw !== eo) begin bad++; $display("FAIL lanes_ovrflw: got %b want %b", Ovrflw, eo); end
    endtask

    task automatic test_ignored_start;
        int ndone; bit seen; logic [255:0] ep; logic eo;
        q_prod.push_back({16{16'h4200}}); q_ov.push_back(1'b0);
        scalar = 16'h4000; vecin = {16{16'h3e00}}; start = 1'b1;
        @(negedge clk);
        scalar = 16'h3c00; vecin = '0; start = 1'b1;
        @(negedge clk);
        scalar = 16'h7bff; vecin = {16{16'h7bff}}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ndone++;
                if (!seen) begin
                    seen = 1'b1;
                    ep = q_prod.pop_front(); eo = q_ov.pop_front();
                    total++; if (product !== ep) begin bad++; $display("FAIL ignored_product: got %h want %h", product, ep); end
                    total++; if (Ovrflw !== eo) begin bad++; $display("FAIL ignored_ovrflw: got %b want %b", Ovrflw, eo); end
                end
            end
            @(negedge clk);
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignored_done_count: got %0d want 1", ndone); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; scalar = '0; vecin = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_sign_b2b();
        test_overflow_all();
        test_reset_mid();
        test_single_lane();
        test_lanes();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
